// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: error classification, column-code generator and
// the legality rule tying PARITY_WIDTH to DATA_WIDTH.
package ecc_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        SBIT = 2'd1,
        DBIT = 2'd2
    } err_type_e;

    localparam int COL_MAX_W = 16;

    // Column of data bit idx: the idx-th non-power-of-two Hamming position,
    // with the top parity bit added so every column has odd weight.
    function automatic logic [COL_MAX_W-1:0] col_code(input int idx, input int pw);
        logic [COL_MAX_W-1:0] code;
        int                   cnt;
        code = '0;
        cnt  = 0;
        for (int v = 3; v < (1 << (pw - 1)); v++) begin
            if ((v & (v - 1)) != 0) begin
                if (cnt == idx) begin
                    code = COL_MAX_W'(v);
                end else begin
                    code = code;
                end
                cnt++;
            end else begin
                cnt = cnt;
            end
        end
        if (^code) begin
            code = code;
        end else begin
            code = code | (COL_MAX_W'(1) << (pw - 1));
        end
        return code;
    endfunction

    function automatic bit pw_legal(input int dw, input int pw);
        return (dw >= 4) && (dw <= 247) && (pw >= 3) && (pw <= COL_MAX_W) &&
               ((1 << (pw - 1)) >= (dw + pw));
    endfunction

endpackage

// File: rtl/ecc_secded_pipe_if.sv
// Beat-level handshake bundle between an upstream producer/downstream consumer
// (master side) and the ecc_secded_pipe datapath (slave side).
interface ecc_secded_pipe_if #(
    parameter int DATA_WIDTH   = 57,
    parameter int PARITY_WIDTH = 7
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [PARITY_WIDTH-1:0] in_parity;
    logic                    bypass;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [PARITY_WIDTH-1:0] out_parity;
    logic                    sbit_err;
    logic                    dbit_err;

    modport master (
        output in_valid, in_data, in_parity, bypass, out_ready,
        input  in_ready, out_valid, out_data, out_parity, sbit_err, dbit_err
    );

    modport slave (
        input  in_valid, in_data, in_parity, bypass, out_ready,
        output in_ready, out_valid, out_data, out_parity, sbit_err, dbit_err
    );
endinterface

// File: rtl/ecc_secded_core.sv
// Combinational SECDED encode/syndrome/correct. Optional error injection into
// the decoder path is enabled with ECC_ERR_INJECT_EN.
module ecc_secded_core
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH   = 57,
    parameter int PARITY_WIDTH = 7
) (
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [PARITY_WIDTH-1:0] parity_i,
`ifdef ECC_ERR_INJECT_EN
    input  logic                    inj_en_i,
    input  logic [DATA_WIDTH-1:0]   inj_mask_i,
`endif
    output logic [PARITY_WIDTH-1:0] enc_o,
    output logic [PARITY_WIDTH-1:0] syn_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output err_type_e               err_o
);

    if (!pw_legal(DATA_WIDTH, PARITY_WIDTH)) begin : g_bad_cfg
        $fatal(1, "ecc_secded_core: PARITY_WIDTH too small for DATA_WIDTH");
    end

    function automatic logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] build_cols();
        logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] cols;
        logic [COL_MAX_W-1:0]                    code;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            code    = col_code(i, PARITY_WIDTH);
            cols[i] = code[PARITY_WIDTH-1:0];
        end
        return cols;
    endfunction

    localparam logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] COLS = build_cols();

    function automatic logic [PARITY_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [PARITY_WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            p = p ^ (COLS[i] & {PARITY_WIDTH{d[i]}});
        end
        return p;
    endfunction

    logic [DATA_WIDTH-1:0] dec_data_s;
    logic [DATA_WIDTH-1:0] flip_s;

    assign enc_o = encode(data_i);
`ifdef ECC_ERR_INJECT_EN
    assign dec_data_s = data_i ^ (inj_mask_i & {DATA_WIDTH{inj_en_i}});
    assign syn_o      = parity_i ^ encode(dec_data_s);
`else
    assign dec_data_s = data_i;
    assign syn_o      = parity_i ^ enc_o;
`endif

    // Data columns have odd weight >= 3, so they never alias a one-hot parity syndrome.
    always_comb begin
        flip_s = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            flip_s[i] = (syn_o == COLS[i]);
        end
        if (syn_o == '0) begin
            err_o = NONE;
        end else if (|flip_s) begin
            err_o = SBIT;
        end else if ($onehot(syn_o)) begin
            err_o = SBIT;
        end else begin
            err_o = DBIT;
        end
    end

    assign data_o = dec_data_s ^ flip_s;

endmodule

// File: rtl/ecc_secded_pipe.sv
// One-stage SECDED check/correct pipeline with valid/ready handshake, saturating
// error counters and first-error syndrome log. Optional macro: ECC_ERR_INJECT_EN.
module ecc_secded_pipe
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH   = 57,
    parameter int PARITY_WIDTH = 7,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ecc_secded_pipe_if.slave        bus,
    input  logic                    cnt_clr,
`ifdef ECC_ERR_INJECT_EN
    input  logic                    inj_en,
    input  logic [DATA_WIDTH-1:0]   inj_mask,
`endif
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic [PARITY_WIDTH-1:0] first_syn,
    output logic                    err_seen
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PARITY_WIDTH-1:0] enc_s, syn_s;
    logic [DATA_WIDTH-1:0]   cor_s;
    err_type_e               err_s;
    logic                    accept_s, count_s;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [PARITY_WIDTH-1:0] out_parity_q, out_parity_d;
    logic                    sbit_q, sbit_d, dbit_q, dbit_d;
    logic [CNT_WIDTH-1:0]    sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
    logic [PARITY_WIDTH-1:0] first_syn_q, first_syn_d;
    logic                    err_seen_q, err_seen_d;

    ecc_secded_core #(
        .DATA_WIDTH   (DATA_WIDTH),
        .PARITY_WIDTH (PARITY_WIDTH)
    ) u_core (
        .data_i     (bus.in_data),
        .parity_i   (bus.in_parity),
`ifdef ECC_ERR_INJECT_EN
        .inj_en_i   (inj_en),
        .inj_mask_i (inj_mask),
`endif
        .enc_o      (enc_s),
        .syn_o      (syn_s),
        .data_o     (cor_s),
        .err_o      (err_s)
    );

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign count_s      = accept_s && !bus.bypass && (err_s != NONE);

    // Output stage: load on accept, drain when consumed, otherwise hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        sbit_d       = sbit_q;
        dbit_d       = dbit_q;
        if (accept_s) begin
            out_valid_d  = 1'b1;
            out_parity_d = enc_s;
            if (bus.bypass) begin
                out_data_d = bus.in_data;
                sbit_d     = 1'b0;
                dbit_d     = 1'b0;
            end else begin
                out_data_d = cor_s;
                sbit_d     = (err_s == SBIT);
                dbit_d     = (err_s == DBIT);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Error statistics; clear has priority over a same-cycle increment.
    always_comb begin
        sbit_cnt_d  = sbit_cnt_q;
        dbit_cnt_d  = dbit_cnt_q;
        first_syn_d = first_syn_q;
        err_seen_d  = err_seen_q;
        if (cnt_clr) begin
            sbit_cnt_d  = '0;
            dbit_cnt_d  = '0;
            first_syn_d = '0;
            err_seen_d  = 1'b0;
        end else begin
            if (count_s && (err_s == SBIT) && (sbit_cnt_q != CNT_MAX)) begin
                sbit_cnt_d = sbit_cnt_q + CNT_WIDTH'(1);
            end else begin
                sbit_cnt_d = sbit_cnt_q;
            end
            if (count_s && (err_s == DBIT) && (dbit_cnt_q != CNT_MAX)) begin
                dbit_cnt_d = dbit_cnt_q + CNT_WIDTH'(1);
            end else begin
                dbit_cnt_d = dbit_cnt_q;
            end
            if (count_s && !err_seen_q) begin
                first_syn_d = syn_s;
                err_seen_d  = 1'b1;
            end else begin
                first_syn_d = first_syn_q;
            end
        end
    end

    // State registers; reset also drops any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= '0;
            sbit_q       <= 1'b0;
            dbit_q       <= 1'b0;
            sbit_cnt_q   <= '0;
            dbit_cnt_q   <= '0;
            first_syn_q  <= '0;
            err_seen_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
            sbit_q       <= sbit_d;
            dbit_q       <= dbit_d;
            sbit_cnt_q   <= sbit_cnt_d;
            dbit_cnt_q   <= dbit_cnt_d;
            first_syn_q  <= first_syn_d;
            err_seen_q   <= err_seen_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_parity = out_parity_q;
    assign bus.sbit_err   = sbit_q;
    assign bus.dbit_err   = dbit_q;
    assign sbit_cnt       = sbit_cnt_q;
    assign dbit_cnt       = dbit_cnt_q;
    assign first_syn      = first_syn_q;
    assign err_seen       = err_seen_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed, table-driven bench for ecc_secded_pipe (default and CNT_WIDTH=4 builds).
module tb_ecc_secded_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ecc_secded_pipe_if #(.DATA_WIDTH(57), .PARITY_WIDTH(7)) bus  ();
    ecc_secded_pipe_if #(.DATA_WIDTH(57), .PARITY_WIDTH(7)) bus4 ();

    logic        cnt_clr, cnt_clr4;
    logic [15:0] sbit_cnt, dbit_cnt;
    logic [3:0]  sbit_cnt4, dbit_cnt4;
    logic [6:0]  first_syn, first_syn4;
    logic        err_seen, err_seen4;
`ifdef ECC_ERR_INJECT_EN
    logic        inj_en   = 1'b0;
    logic [56:0] inj_mask = '0;
`endif

    ecc_secded_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
`ifdef ECC_ERR_INJECT_EN
        .inj_en    (inj_en),
        .inj_mask  (inj_mask),
`endif
        .sbit_cnt  (sbit_cnt),
        .dbit_cnt  (dbit_cnt),
        .first_syn (first_syn),
        .err_seen  (err_seen)
    );

    ecc_secded_pipe #(.CNT_WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus4),
        .cnt_clr   (cnt_clr4),
`ifdef ECC_ERR_INJECT_EN
        .inj_en    (inj_en),
        .inj_mask  (inj_mask),
`endif
        .sbit_cnt  (sbit_cnt4),
        .dbit_cnt  (dbit_cnt4),
        .first_syn (first_syn4),
        .err_seen  (err_seen4)
    );

    typedef struct {
        logic [56:0] data;
        logic [6:0]  parity;
        logic        byp;
        logic [56:0] exp_data;
        logic [6:0]  exp_par;
        logic        exp_s;
        logic        exp_d;
        logic [15:0] exp_scnt;
        logic [15:0] exp_dcnt;
        logic [6:0]  exp_fsyn;
    } vec_t;

    vec_t vecs [11];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [56:0] pat(input int k);
        return 57'h0AB_CDEF_0000_0000 ^ 57'(k * 3 + 1);
    endfunction

    initial begin
        // Columns: bit0=43 bit1=45 bit2=46 bit3=07 bit4=49 bit56=7F.
        vecs[0]  = '{57'h0, 7'h00, 1'b0, 57'h0, 7'h00, 1'b0, 1'b0, 16'd0, 16'd0, 7'h00};
        vecs[1]  = '{57'h1, 7'h00, 1'b0, 57'h0, 7'h43, 1'b1, 1'b0, 16'd1, 16'd0, 7'h43};
        vecs[2]  = '{57'h3, 7'h00, 1'b0, 57'h3, 7'h06, 1'b0, 1'b1, 16'd1, 16'd1, 7'h43};
        vecs[3]  = '{57'h0, 7'h01, 1'b0, 57'h0, 7'h00, 1'b1, 1'b0, 16'd2, 16'd1, 7'h43};
        vecs[4]  = '{57'h8, 7'h07, 1'b0, 57'h8, 7'h07, 1'b0, 1'b0, 16'd2, 16'd1, 7'h43};
        vecs[5]  = '{57'h100_0000_0000_0000, 7'h00, 1'b0, 57'h0, 7'h7F, 1'b1, 1'b0, 16'd3, 16'd1, 7'h43};
        vecs[6]  = '{57'h08, 7'h4E, 1'b0, 57'h18, 7'h07, 1'b1, 1'b0, 16'd4, 16'd1, 7'h43};
        vecs[7]  = '{57'h0, 7'h40, 1'b0, 57'h0, 7'h00, 1'b1, 1'b0, 16'd5, 16'd1, 7'h43};
        vecs[8]  = '{57'h3, 7'h00, 1'b1, 57'h3, 7'h06, 1'b0, 1'b0, 16'd5, 16'd1, 7'h43};
        vecs[9]  = '{57'h5, 7'h00, 1'b0, 57'h5, 7'h05, 1'b0, 1'b1, 16'd5, 16'd2, 7'h43};
        vecs[10] = '{57'h0, 7'h03, 1'b0, 57'h0, 7'h00, 1'b0, 1'b1, 16'd5, 16'd3, 7'h43};

        bus.in_valid  = 1'b0; bus.in_data  = '0; bus.in_parity  = '0; bus.bypass  = 1'b0; bus.out_ready  = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_parity = '0; bus4.bypass = 1'b0; bus4.out_ready = 1'b1;
        cnt_clr = 1'b0; cnt_clr4 = 1'b0;

        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_sbit_cnt", 64'(sbit_cnt), 64'd0);
        check("rst_err_seen", 64'(err_seen), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;

        // Back-to-back table beats with out_ready held high.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_data   = vecs[i].data;
            bus.in_parity = vecs[i].parity;
            bus.bypass    = vecs[i].byp;
            @(posedge clk); #1;
            check($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("v%0d_data", i), 64'(bus.out_data), 64'(vecs[i].exp_data));
            check($sformatf("v%0d_parity", i), 64'(bus.out_parity), 64'(vecs[i].exp_par));
            check($sformatf("v%0d_sbit", i), 64'(bus.sbit_err), 64'(vecs[i].exp_s));
            check($sformatf("v%0d_dbit", i), 64'(bus.dbit_err), 64'(vecs[i].exp_d));
            check($sformatf("v%0d_scnt", i), 64'(sbit_cnt), 64'(vecs[i].exp_scnt));
            check($sformatf("v%0d_dcnt", i), 64'(dbit_cnt), 64'(vecs[i].exp_dcnt));
            check($sformatf("v%0d_fsyn", i), 64'(first_syn), 64'(vecs[i].exp_fsyn));
            check($sformatf("v%0d_seen", i), 64'(err_seen),
                  64'((vecs[i].exp_scnt + vecs[i].exp_dcnt) != 16'd0));
        end
        @(negedge clk) bus.in_valid = 1'b0;

        @(negedge clk) cnt_clr = 1'b1;
        @(posedge clk); #1;
        check("clr_scnt", 64'(sbit_cnt), 64'd0);
        check("clr_dcnt", 64'(dbit_cnt), 64'd0);
        check("clr_fsyn", 64'(first_syn), 64'd0);
        check("clr_seen", 64'(err_seen), 64'd0);
        @(negedge clk) cnt_clr = 1'b0;

        // Streaming with out_ready toggling; bypass keeps data recognisable.
        begin
            int          sent = 0;
            int          rcvd = 0;
            logic        stalled = 1'b0;
            logic [56:0] held = '0;
            for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
                @(negedge clk);
                if (stalled) begin
                    check("stall_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_data", 64'(bus.out_data), 64'(held));
                end
                bus.out_ready = ((cyc % 2) == 0);
                bus.in_valid  = (sent < 8);
                bus.in_data   = pat(sent);
                bus.in_parity = 7'h00;
                bus.bypass    = 1'b1;
                #1;
                if (bus.out_valid && bus.out_ready) begin
                    check($sformatf("stream_beat%0d", rcvd), 64'(bus.out_data), 64'(pat(rcvd)));
                    check("stream_noerr", 64'({bus.sbit_err, bus.dbit_err}), 64'd0);
                    rcvd++;
                end
                stalled = bus.out_valid && !bus.out_ready;
                held    = bus.out_data;
                if (bus.in_valid && bus.in_ready) sent++;
            end
            check("stream_count", 64'(rcvd), 64'd8);
            check("stream_not_counted", 64'(sbit_cnt), 64'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.bypass = 1'b0; bus.out_ready = 1'b1;

        // Saturation and clear-beats-increment on the 4-bit-counter instance.
        @(negedge clk);
        bus4.in_valid = 1'b1; bus4.in_data = 57'h1; bus4.in_parity = 7'h00;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("sat_scnt", 64'(sbit_cnt4), 64'd15);
        check("sat_dcnt", 64'(dbit_cnt4), 64'd0);
        check("sat_fsyn", 64'(first_syn4), 64'h43);
        check("sat_seen", 64'(err_seen4), 64'd1);
        cnt_clr4 = 1'b1;
        @(posedge clk); #1;
        check("clrwin_scnt", 64'(sbit_cnt4), 64'd0);
        check("clrwin_seen", 64'(err_seen4), 64'd0);
        check("clrwin_fsyn", 64'(first_syn4), 64'd0);
        @(negedge clk) cnt_clr4 = 1'b0;
        @(posedge clk); #1;
        check("after_clr_scnt", 64'(sbit_cnt4), 64'd1);
        @(negedge clk) bus4.in_valid = 1'b0;

        // Reset while a stalled beat is held.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 57'h1; bus.in_parity = 7'h00; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("prerst_valid", 64'(bus.out_valid), 64'd1);
        check("prerst_scnt", 64'(sbit_cnt), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_data", 64'(bus.out_data), 64'd0);
        check("midrst_parity", 64'(bus.out_parity), 64'd0);
        check("midrst_sbit", 64'(bus.sbit_err), 64'd0);
        check("midrst_scnt", 64'(sbit_cnt), 64'd0);
        check("midrst_fsyn", 64'(first_syn), 64'd0);
        check("midrst_seen", 64'(err_seen), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 57'h8; bus.in_parity = 7'h07; bus.out_ready = 1'b1;
        #1;
        check("postrst_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        check("postrst_valid", 64'(bus.out_valid), 64'd1);
        check("postrst_data", 64'(bus.out_data), 64'h8);
        check("postrst_sbit", 64'(bus.sbit_err), 64'd0);
        @(negedge clk) bus.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_secded_pipe.md
ECC_SECDED_PIPE -- requirements
Module: ecc_secded_pipe

Interface
REQ-001 DATA_WIDTH, 57, number of protected data bits (4..247).
REQ-002 PARITY_WIDTH, 7, check bits; must satisfy 2^(PARITY_WIDTH-1) >= DATA_WIDTH+PARITY_WIDTH; the block SHALL stop elaboration with a fatal error otherwise.
REQ-003 CNT_WIDTH, 16, width of the error counters.
REQ-004 Single clock `clk`; reset `rst_n`, asynchronous, active-low.
REQ-005 Ports (name direction width meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when high with in_valid
- in_data  in  DATA_WIDTH  raw data
- in_parity  in  PARITY_WIDTH  stored check bits
- bypass  in  1  sampled with beat; pass data unchecked
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  corrected data
- out_parity  out  PARITY_WIDTH  check bits encoded from in_data of the same beat
- sbit_err  out  1  single-bit error on the output beat
- dbit_err  out  1  uncorrectable error on the output beat
- cnt_clr  in  1  synchronous clear of counters and log
- sbit_cnt  out  CNT_WIDTH  saturating single-error count
- dbit_cnt  out  CNT_WIDTH  saturating double-error count
- first_syn  out  PARITY_WIDTH  syndrome of the first error since clear
- err_seen  out  1  sticky flag, high once any error has been logged

Function
REQ-006 Encoding: data bit i SHALL use as its column the i-th non-power-of-two Hamming position code (3,5,6,7,9,...) in parity bits [PARITY_WIDTH-2:0]; parity bit PARITY_WIDTH-1 SHALL be set so that every column has odd weight.
REQ-007 syndrome = in_parity XOR encode(in_data); this SHALL be purely combinational ahead of the stage register.
REQ-008 Decode: zero gives no error. A value equal to a data column flips that bit and sets sbit. A single-hot value is a parity-bit error: sbit set, data unchanged. Any other value sets dbit, and data passes uncorrected.
REQ-009 A single register stage SHALL hold out_data, out_parity, sbit_err and dbit_err; latency from acceptance to out_valid is 1 cycle.
REQ-010 in_ready = !out_valid || out_ready; sustained throughput is 1 beat per cycle with no bubbles.
REQ-011 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-012 If the beat was accepted with bypass=1, out_data=in_data, sbit_err=dbit_err=0, and the beat is not counted.
REQ-013 Counters SHALL increment on acceptance of an erroring beat and saturate at 2^CNT_WIDTH-1.
REQ-014 cnt_clr SHALL zero both counters, first_syn and err_seen next cycle; clear wins over a simultaneous increment.
REQ-015 On the first counted error while err_seen=0, the block SHALL capture first_syn and set err_seen; later errors SHALL NOT overwrite first_syn.

Reset
REQ-016 rst_n low SHALL asynchronously zero out_valid, out_data, out_parity, sbit_err, dbit_err, both counters, first_syn and err_seen.
REQ-017 An in-flight beat SHALL be discarded on reset; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-018 With ECC_ERR_INJECT_EN defined, the block SHALL add inputs inj_en (1) and inj_mask (DATA_WIDTH); when inj_en=1, inj_mask XOR in_data SHALL feed the decoder, with encoding from the unmodified in_data.
REQ-019 Without ECC_ERR_INJECT_EN, those ports and that logic SHALL be absent and behaviour SHALL equal inj_en=0.

Structure
REQ-020 A shared package ecc_pkg SHALL hold the column-code generation function, the PARITY_WIDTH legality check function and the error-type enum (NONE, SBIT, DBIT).
REQ-021 Sub-module ecc_secded_core SHALL be purely combinational (encode, syndrome, mask, error type); ecc_secded_pipe SHALL add the stage, handshake, counters and log.

Verification
REQ-022 Defaults, in_data=0, in_parity=0 -> out_data=0, out_parity=0, no error, 1 cycle later.
REQ-023 in_data=57'h1, in_parity=0 -> syndrome 7'h43, out_data=0, sbit_err=1, sbit_cnt=1, first_syn=7'h43, err_seen=1.
REQ-024 in_data=57'h3, in_parity=0 -> dbit_err=1, out_data=57'h3, dbit_cnt=1; then in_parity=7'h01 with clean data -> sbit_err=1, data unchanged.
REQ-025 Streaming 8 beats with out_ready toggling 1/0 -> no loss or duplication, order preserved, outputs stable while stalled.
REQ-026 CNT_WIDTH=4, 20 single-error beats -> sbit_cnt=15; cnt_clr in the same cycle as an error beat -> sbit_cnt=0, err_seen=0.
REQ-027 rst_n asserted with out_valid=1 mid-stall -> all outputs 0 immediately; first beat after release is accepted.
